// File: rtl/minrv32_sram_ctrl.sv
// rtl/minrv32_sram_ctrl.sv - minrv32 native-bus SRAM stage with byte-lane writes and wait states
// Optional range checking is enabled by defining MINRV32_MEM_BOUNDS_EN.
module minrv32_sram_ctrl #(
    parameter int unsigned DEPTH       = 16384,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int unsigned WAIT_STATES = 0,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);
    localparam int IDXW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        latch;
    logic        enter_done;

    logic [31:0] acc_addr, acc_wdata, offset;
    logic [3:0]  acc_wstrb;
    logic [IDXW-1:0] idx;
    logic        in_range;
    logic        do_write, do_read;

    logic [31:0] mem [DEPTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        latch      = 1'b0;
        enter_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d    = S_DONE;
                    enter_done = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the accept edge, so use the live bus fields.
    assign acc_addr  = (state_q == S_IDLE) ? mem_addr  : addr_q;
    assign acc_wdata = (state_q == S_IDLE) ? mem_wdata : wdata_q;
    assign acc_wstrb = (state_q == S_IDLE) ? mem_wstrb : wstrb_q;
    assign offset    = acc_addr - BASE_ADDR;
    assign idx       = IDXW'(offset >> 2);

`ifdef MINRV32_MEM_BOUNDS_EN
    localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;
    logic err_q;
    assign in_range = ({1'b0, offset} < SPAN);
`else
    assign in_range = 1'b1;
`endif

    assign do_write = enter_done && !reset && in_range && (acc_wstrb != 4'd0);
    assign do_read  = enter_done && in_range && (acc_wstrb == 4'd0);

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            instr_q <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= 32'd0;
`ifdef MINRV32_MEM_BOUNDS_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= enter_done;
            rdata_q <= do_read ? mem[idx] : 32'd0;
`ifdef MINRV32_MEM_BOUNDS_EN
            err_q   <= enter_done && !in_range;
`endif
            if (latch) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
`ifdef MINRV32_MEM_BOUNDS_EN
    assign mem_err   = err_q;
`else
    assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_minrv32_sram_ctrl.sv
// tb/tb_minrv32_sram_ctrl.sv - directed checks of minrv32_sram_ctrl with zero and three wait states
module tb_minrv32_sram_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid0, instr0, valid3, instr3;
    logic [31:0] addr0, wdata0, addr3, wdata3;
    logic [3:0]  wstrb0, wstrb3;
    logic        ready0, err0, ready3, err3;
    logic [31:0] rdata0, rdata3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    minrv32_sram_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .mem_valid(valid0), .mem_instr(instr0),
        .mem_addr(addr0), .mem_wdata(wdata0), .mem_wstrb(wstrb0),
        .mem_ready(ready0), .mem_rdata(rdata0), .mem_err(err0)
    );

    minrv32_sram_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .reset(reset), .mem_valid(valid3), .mem_instr(instr3),
        .mem_addr(addr3), .mem_wdata(wdata3), .mem_wstrb(wstrb3),
        .mem_ready(ready3), .mem_rdata(rdata3), .mem_err(err3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Issue one request on dut d starting in an IDLE cycle; returns after the following IDLE cycle begins.
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input logic ins, output logic [31:0] rd, output logic er, output int lat);
        logic r;
        if (d == 0) begin
            valid0 = 1'b1; addr0 = a; wdata0 = wd; wstrb0 = ws; instr0 = ins;
        end else begin
            valid3 = 1'b1; addr3 = a; wdata3 = wd; wstrb3 = ws; instr3 = ins;
        end
        lat = 0;
        r   = 1'b0;
        while (!r) begin
            @(posedge clk); #1;
            lat++;
            r = (d == 0) ? ready0 : ready3;
            if (!r) begin
                check("rdata_zero_while_waiting", (d == 0) ? rdata0 : rdata3, 32'd0);
                if (lat >= 40) begin
                    check("ready_timeout", {31'd0, r}, 32'd1);
                    r = 1'b1;
                end
            end
        end
        rd = (d == 0) ? rdata0 : rdata3;
        er = (d == 0) ? err0 : err3;
        valid0 = 1'b0;
        valid3 = 1'b0;
        @(posedge clk); #1;
        check("ready_single_cycle", {31'd0, (d == 0) ? ready0 : ready3}, 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        reset = 1'b1;
        valid0 = 1'b0; instr0 = 1'b0; addr0 = '0; wdata0 = '0; wstrb0 = '0;
        valid3 = 1'b0; instr3 = 1'b0; addr3 = '0; wdata3 = '0; wstrb3 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_ready0", {31'd0, ready0}, 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_err0", {31'd0, err0}, 32'd0);
        check("reset_ready3", {31'd0, ready3}, 32'd0);
        check("reset_rdata3", rdata3, 32'd0);

        // Zero wait states: full-word write and read back
        txn(0, 32'h0001_0000, 32'h0BAD_F00D, 4'hF, 1'b0, rd, er, lat);
        txn(0, 32'h0001_0008, 32'h7777_8888, 4'hF, 1'b0, rd, er, lat);
        txn(0, 32'h0001_0004, 32'hDEAD_BEEF, 4'hF, 1'b0, rd, er, lat);
        check("ws0_write_latency", lat, 1);
        check("ws0_write_rdata", rd, 32'd0);
        txn(0, 32'h0001_0004, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("ws0_read_latency", lat, 1);
        check("ws0_read_data", rd, 32'hDEAD_BEEF);
        check("ws0_read_err", {31'd0, er}, 32'd0);

        // Single byte lane write
        txn(0, 32'h0001_0004, 32'h0000_AB00, 4'b0010, 1'b0, rd, er, lat);
        txn(0, 32'h0001_0004, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("byte_lane_merge", rd, 32'hDEAD_ABEF);
        txn(0, 32'h0001_0000, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("neighbour_below", rd, 32'h0BAD_F00D);
        txn(0, 32'h0001_0008, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("neighbour_above", rd, 32'h7777_8888);
        txn(0, 32'h0001_0006, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("low_addr_bits_ignored", rd, 32'hDEAD_ABEF);

        // Three wait states
        txn(1, 32'h0001_0008, 32'h1111_1111, 4'hF, 1'b0, rd, er, lat);
        check("ws3_write_latency", lat, 4);
        txn(1, 32'h0001_0008, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("ws3_read_latency", lat, 4);
        check("ws3_read_data", rd, 32'h1111_1111);

        // Reset during WAIT aborts the write
        valid3 = 1'b1; addr3 = 32'h0001_0008; wdata3 = 32'h1234_5678; wstrb3 = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b1;
        valid3 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("no_ready_after_abort", {31'd0, ready3}, 32'd0);
            @(posedge clk); #1;
        end
        txn(1, 32'h0001_0008, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("aborted_write_dropped", rd, 32'h1111_1111);

        // Reset and request in the same cycle: reset wins
        valid0 = 1'b1; addr0 = 32'h0001_0004; wstrb0 = 4'h0;
        reset  = 1'b1;
        @(posedge clk); #1;
        reset  = 1'b0;
        valid0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("reset_beats_valid", {31'd0, ready0}, 32'd0);
            @(posedge clk); #1;
        end

`ifdef MINRV32_MEM_BOUNDS_EN
        txn(0, 32'h0000_0000, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("oob_latency", lat, 1);
        check("oob_err", {31'd0, er}, 32'd1);
        check("oob_rdata", rd, 32'd0);
        txn(0, 32'h0001_0000 + 4 * DEPTH, 32'h55AA_55AA, 4'hF, 1'b0, rd, er, lat);
        check("oob_write_err", {31'd0, er}, 32'd1);
        txn(0, 32'h0001_0000, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("oob_write_dropped", rd, 32'h0BAD_F00D);
        check("inrange_err", {31'd0, er}, 32'd0);
`else
        txn(0, 32'h0001_0000 + 4 * DEPTH, 32'h55AA_55AA, 4'hF, 1'b0, rd, er, lat);
        check("alias_write_err", {31'd0, er}, 32'd0);
        txn(0, 32'h0001_0000, 32'd0, 4'h0, 1'b0, rd, er, lat);
        check("alias_read_data", rd, 32'h55AA_55AA);
        check("alias_read_err", {31'd0, er}, 32'd0);
`endif

        // Back-to-back: next request raised in the IDLE cycle right after ready
        txn(0, 32'h0001_0010, 32'hCAFE_F00D, 4'hF, 1'b0, rd, er, lat);
        txn(0, 32'h0001_0010, 32'd0, 4'h0, 1'b1, rd, er, lat);
        check("b2b_ws0_latency", lat, 1);
        check("b2b_ws0_fetch", rd, 32'hCAFE_F00D);
        txn(1, 32'h0001_0010, 32'h0102_0304, 4'hF, 1'b0, rd, er, lat);
        txn(1, 32'h0001_0010, 32'd0, 4'h0, 1'b1, rd, er, lat);
        check("b2b_ws3_latency", lat, 4);
        check("b2b_ws3_fetch", rd, 32'h0102_0304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
